// File: rtl/addsub_serial.sv
// addsub_serial: chunk-serial add/subtract with unsigned/signed overflow detection and optional saturation
// Ports: clk, reset_n (async, active low); start/add_sub/signed_mode/sat_en/dataa/datab request an operation;
// busy is high while chunks are being summed, done pulses once when result/carry_out/overflow update.
module addsub_serial #(
  parameter int dw = 16,
  parameter int cw = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          add_sub,
  input  logic          signed_mode,
  input  logic          sat_en,
  input  logic [dw-1:0] dataa,
  input  logic [dw-1:0] datab,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] result,
  output logic          carry_out,
  output logic          overflow
);
  localparam int n = dw / cw;
  localparam int iw = n > 1 ? $clog2(n) : 1;
  if (dw % cw != 0) begin : g_bad_width
    $error("addsub_serial: dw must be a multiple of cw");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          st_q;
  logic [dw-1:0]   a_q, b_q, sum_q, sum_d, res_d, sat_d;
  logic [iw-1:0]   idx_q;
  logic            add_q, sgn_q, sat_q, cy_q, sa, sb, ov_d;
  logic [cw-1:0]   ac, bc;
  logic [cw:0]     cs;
  always_comb begin
    ac = a_q[idx_q*cw +: cw];
    bc = add_q ? b_q[idx_q*cw +: cw] : ~b_q[idx_q*cw +: cw];
    cs = {1'b0, ac} + {1'b0, bc} + {{cw{1'b0}}, cy_q};
    sum_d = sum_q;
    sum_d[idx_q*cw +: cw] = cs[cw-1:0];
    sa = a_q[dw-1];
    sb = add_q ? b_q[dw-1] : ~b_q[dw-1];
    // only meaningful on the last chunk, where cs[cw] is the full-width carry
    ov_d = sgn_q ? (sa == sb && sum_d[dw-1] != sa) : (add_q ? cs[cw] : ~cs[cw]);
    sat_d = sgn_q ? {sa, {(dw-1){~sa}}} : {dw{add_q}};
    res_d = (sat_q && ov_d) ? sat_d : sum_d;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st_q      <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      add_q     <= 1'b0;
      sgn_q     <= 1'b0;
      sat_q     <= 1'b0;
      cy_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st_q)
        IDLE, DONE:
          if (start) begin
            st_q  <= RUN;
            busy  <= 1'b1;
            a_q   <= dataa;
            b_q   <= datab;
            add_q <= add_sub;
            sgn_q <= signed_mode;
            sat_q <= sat_en;
            cy_q  <= ~add_sub;
            idx_q <= '0;
            sum_q <= '0;
          end else st_q <= IDLE;
        RUN: begin
          cy_q  <= cs[cw];
          sum_q <= sum_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == iw'(n - 1)) begin
            st_q      <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= res_d;
            carry_out <= cs[cw];
            overflow  <= ov_d;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vectors against an arithmetic reference model of addsub_serial (dw=8, cw=4)
module tb_addsub_serial;
  localparam int dw = 8;
  localparam int cw = 4;
  localparam int n = dw / cw;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, add_sub = 1'b0, signed_mode = 1'b0, sat_en = 1'b0;
  logic [dw-1:0] dataa = '0, datab = '0;
  logic          busy, done, carry_out, overflow;
  logic [dw-1:0] result;
  int            errors = 0, checks = 0;
  addsub_serial #(.dw(dw), .cw(cw)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .add_sub(add_sub),
    .signed_mode(signed_mode), .sat_en(sat_en), .dataa(dataa), .datab(datab),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference arithmetic: {result, carry_out, overflow}
  function automatic logic [dw+1:0] calc(input logic [dw-1:0] a, b, input logic ad, sg, st);
    logic [dw:0]   u;
    logic [dw-1:0] r;
    logic          ov;
    int            sa, sb, sv;
    u  = ad ? {1'b0, a} + {1'b0, b} : {1'b0, a} + (9'd256 - {1'b0, b});
    r  = u[dw-1:0];
    sa = $signed(a);
    sb = $signed(b);
    sv = ad ? sa + sb : sa - sb;
    ov = sg ? (sv > 127 || sv < -128) : (ad ? u[dw] : !u[dw]);
    if (st && ov) r = sg ? (sa < 0 ? 8'h80 : 8'h7F) : (ad ? 8'hFF : 8'h00);
    return {r, u[dw], ov};
  endfunction
  int            m_cnt;
  logic          m_busy, m_done, m_co, m_ov, m_add, m_sgn, m_sat;
  logic [dw-1:0] m_res, m_a, m_b;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_cnt <= 0; m_busy <= 0; m_done <= 0; m_res <= '0; m_co <= 0; m_ov <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= n; m_busy <= 1'b1;
          m_a <= dataa; m_b <= datab; m_add <= add_sub; m_sgn <= signed_mode; m_sat <= sat_en;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_res, m_co, m_ov} <= calc(m_a, m_b, m_add, m_sgn, m_sat);
        end
      end
    end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("result", result, m_res);
    chk("carry_out", carry_out, m_co);
    chk("overflow", overflow, m_ov);
  end
  task automatic wait_done(input string name, input int exp_k);
    int k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, k, exp_k);
  endtask
  task automatic op(input string name, input logic [dw-1:0] a, b, input logic ad, sg, st,
                    input logic [dw-1:0] er, input logic ec, eo);
    @(negedge clk);
    dataa = a; datab = b; add_sub = ad; signed_mode = sg; sat_en = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, n);
    chk({name, "_res"}, result, er);
    chk({name, "_co"}, carry_out, ec);
    chk({name, "_ov"}, overflow, eo);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_flags", {busy, done, carry_out, overflow}, 0);
    #2 reset_n = 1'b1;
    op("uadd", 8'h3C, 8'h05, 1, 0, 0, 8'h41, 0, 0);
    op("sadd", 8'h7F, 8'h01, 1, 1, 0, 8'h80, 0, 1);
    op("sadd_sat", 8'h7F, 8'h01, 1, 1, 1, 8'h7F, 0, 1);
    op("usub", 8'h05, 8'h0A, 0, 0, 0, 8'hFB, 0, 1);
    op("usub_sat", 8'h05, 8'h0A, 0, 0, 1, 8'h00, 0, 1);
    op("ssub_sat", 8'h80, 8'h01, 0, 1, 1, 8'h80, 1, 1);
    op("uadd_sat", 8'hF0, 8'h20, 1, 0, 1, 8'hFF, 1, 1);
    op("usub_eq", 8'h5A, 8'h5A, 0, 0, 0, 8'h00, 1, 0);
    // start held through RUN with changing operands, then back-to-back from DONE
    @(negedge clk);
    dataa = 8'h10; datab = 8'h20; add_sub = 1; signed_mode = 0; sat_en = 0; start = 1'b1;
    @(negedge clk);
    dataa = 8'h01; datab = 8'h02;
    @(negedge clk);
    dataa = 8'h0A; datab = 8'h05;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_res1", result, 8'h30);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", 2);
    chk("b2b_res2", result, 8'h0F);
    // reset aborts an operation after its first RUN edge
    @(negedge clk);
    dataa = 8'h12; datab = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("abort_outputs", {busy, done, carry_out, overflow, result}, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done, 0);
    #2 reset_n = 1'b1;
    op("after_rst", 8'hFF, 8'h01, 1, 0, 0, 8'h00, 1, 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
